// File: rtl/inst_mem_pipelined.sv
// Byte-addressed big-endian instruction memory with a fixed-latency read pipeline,
// a response queue, a byte programming port and misalignment/range error flags.
module inst_mem_pipelined #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH_BYTES  = 1024,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_DEPTH);
  localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(DEPTH_BYTES);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and rsp_* hold steady while rsp_valid & !rsp_ready.
  logic accept, push, pop;

  // Upper programming address bits are ignored: the memory aliases modulo its size.
  logic unused_prog_hi;
  assign unused_prog_hi = ^prog_addr;

  // ---------------- storage ----------------
  logic [7:0] mem_q [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr[AW-1:0]] <= prog_data;
  end

  // Read is sampled at the accept edge, so a same-edge write is not yet visible.
  logic [AW-1:0] a0;
  logic [1:0]    rd_err;
  logic [31:0]   rd_inst;

  assign a0        = req_addr[AW-1:0];
  assign rd_err[0] = (req_addr[1:0] != 2'b00);
  assign rd_err[1] = ({1'b0, req_addr} >= ADDR_LIM);
  assign rd_inst   = (rd_err != 2'b00) ? 32'h0 :
                     {mem_q[a0], mem_q[a0 + AW'(1)], mem_q[a0 + AW'(2)], mem_q[a0 + AW'(3)]};

  // ---------------- read pipeline ----------------
  logic [READ_LATENCY-1:0] pv_q;
  logic [31:0]       pinst_q [READ_LATENCY];
  logic [ADDR_W-1:0] paddr_q [READ_LATENCY];
  logic [1:0]        perr_q  [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) pv_q[i] <= pv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pinst_q[0] <= rd_inst;
    paddr_q[0] <= req_addr;
    perr_q[0]  <= rd_err;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pinst_q[i] <= pinst_q[i-1];
      paddr_q[i] <= paddr_q[i-1];
      perr_q[i]  <= perr_q[i-1];
    end
  end

  // ---------------- response queue and occupancy ----------------
  logic [31:0]       qinst_q [RSP_DEPTH];
  logic [ADDR_W-1:0] qaddr_q [RSP_DEPTH];
  logic [1:0]        qerr_q  [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, occ_q, occ_d;

  assign push      = pv_q[READ_LATENCY-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  // Occupancy counts in-flight reads too, so an arriving read always finds a free slot.
  assign req_ready = !rst && ((occ_q < CNT_MAX) || pop);
  assign accept    = req_valid && req_ready;

  always_comb begin
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept && !pop)      occ_d = occ_q + CNT_W'(1);
    else if (!accept && pop) occ_d = occ_q - CNT_W'(1);
    if (push && !pop)        cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop)   cnt_d = cnt_q - CNT_W'(1);
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qinst_q[wr_ptr_q] <= pinst_q[READ_LATENCY-1];
      qaddr_q[wr_ptr_q] <= paddr_q[READ_LATENCY-1];
      qerr_q[wr_ptr_q]  <= perr_q[READ_LATENCY-1];
    end
  end

  // Head outputs come straight from registers; gated to zero when the queue is empty.
  assign rsp_inst = rsp_valid ? qinst_q[rd_ptr_q] : 32'h0;
  assign rsp_addr = rsp_valid ? qaddr_q[rd_ptr_q] : '0;
  assign rsp_err  = rsp_valid ? qerr_q[rd_ptr_q]  : 2'b00;

endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Bench for inst_mem_pipelined: directed vectors plus a random phase, checked by an
// expected-response queue drained by an independent monitor.
module tb_inst_mem_pipelined;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 1;
  localparam int RSPD   = 2;
  localparam int W      = 32 + ADDR_W + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_inst;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_err;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [7:0]        prog_data;

  inst_mem_pipelined #(
    .ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT), .RSP_DEPTH(RSPD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int acc_cyc  = 0;
  int rise_cyc = -1;
  logic prev_v = 1'b0;
  int pop_cyc_q[$];

  logic [W-1:0] exp_q[$];
  logic [7:0]   ref_mem [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [ADDR_W-1:0] a);
    logic [1:0]  e;
    logic [31:0] ins;
    int          b;
    e[0] = (a % 4) != 0;
    e[1] = a >= DEPTH;
    b    = int'(a % DEPTH);
    ins  = (e != 2'b00) ? 32'h0 :
           {ref_mem[b], ref_mem[(b + 1) % DEPTH], ref_mem[(b + 2) % DEPTH], ref_mem[(b + 3) % DEPTH]};
    return {ins, a, e};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_byte(input int a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = ADDR_W'(a);
    prog_data = d;
    @(posedge clk);
    ref_mem[a % DEPTH] = d;
    #1;
    prog_we = 1'b0;
  endtask

  task automatic prog_word(input int a, input logic [31:0] w);
    prog_byte(a,     w[31:24]);
    prog_byte(a + 1, w[23:16]);
    prog_byte(a + 2, w[15:8]);
    prog_byte(a + 3, w[7:0]);
  endtask

  task automatic send(input logic [ADDR_W-1:0] a, input logic [31:0] ins, input logic [1:0] e);
    bit got = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({ins, a, e});
        acc_cyc = cyc + 1;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout addr=%0h actual=stalled required=accepted", a);
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_e;
  logic [W-1:0] held;
  bit           hold_pend = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
      prev_v = rsp_valid;
      if (hold_pend && rsp_valid === 1'b1)
        chk("rsp_stable", 64'({rsp_inst, rsp_addr, rsp_err}), 64'(held));
      hold_pend = (rsp_valid === 1'b1) && !rsp_ready;
      held      = {rsp_inst, rsp_addr, rsp_err};
      if (rsp_valid === 1'b1 && rsp_ready) begin
        pop_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp actual=addr %0h required=no response", rsp_addr);
        end else begin
          mon_e = exp_q.pop_front();
          if ({rsp_inst, rsp_addr, rsp_err} !== mon_e) begin
            failures++;
            $display("FAIL rsp actual=inst %h addr %h err %b required=inst %h addr %h err %b",
                     rsp_inst, rsp_addr, rsp_err, mon_e[W-1 -: 32], mon_e[ADDR_W+1:2], mon_e[1:0]);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  int sel;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // programming is legal while reset is held
    prog_word(0, 32'h8C220000);
    prog_word(4, 32'h00221820);
    prog_word(8, 32'h12345678);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_inst",  64'(rsp_inst),  64'd0);
    chk("rst_rsp_addr",  64'(rsp_addr),  64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    tick();
    rst = 1'b0;

    // back-to-back reads, latency and throughput
    rsp_ready = 1'b1;
    pop_cyc_q.delete();
    rise_cyc = -1;
    send(32'h0, 32'h8C220000, 2'b00);
    sel = acc_cyc;
    send(32'h4, 32'h00221820, 2'b00);
    repeat (LAT + 4) tick();
    chk("latency", 64'(rise_cyc - sel), 64'(LAT));
    chk("pop_count", 64'(pop_cyc_q.size()), 64'd2);
    if (pop_cyc_q.size() >= 2) chk("pop_spacing", 64'(pop_cyc_q[1] - pop_cyc_q[0]), 64'd1);

    // backpressure: full after RSP_DEPTH accepts, ready returns with the pop
    rsp_ready = 1'b0;
    send(32'h0, 32'h8C220000, 2'b00);
    send(32'h4, 32'h00221820, 2'b00);
    req_valid = 1'b1;
    req_addr  = 32'h8;
    repeat (LAT + 1) begin
      @(negedge clk);
      chk("full_not_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("ready_with_pop", 64'(req_ready), 64'd1);
    if (req_ready) exp_q.push_back({32'h12345678, 32'h8, 2'b00});
    tick();
    req_valid = 1'b0;
    drain();

    // error flags
    send(32'h2,   32'h0, 2'b01);
    send(32'h400, 32'h0, 2'b10);
    send(32'h402, 32'h0, 2'b11);
    send(32'h404, 32'h0, 2'b10);
    drain();

    // top-of-memory word and same-edge write returning the old byte
    prog_byte(1020, 8'h11);
    prog_byte(1021, 8'h22);
    prog_byte(1022, 8'h33);
    prog_byte(1023, 8'h44);
    send(32'd1020, 32'h11223344, 2'b00);
    req_valid = 1'b1; req_addr = 32'd1020;
    prog_we = 1'b1; prog_addr = 32'd1020; prog_data = 8'hAA;
    @(negedge clk);
    chk("same_edge_ready", 64'(req_ready), 64'd1);
    if (req_ready) exp_q.push_back({32'h11223344, 32'd1020, 2'b00});
    @(posedge clk);
    ref_mem[1020] = 8'hAA;
    #1;
    req_valid = 1'b0; prog_we = 1'b0;
    send(32'd1020, 32'hAA223344, 2'b00);
    drain();

    // reset with one response queued and one read in flight
    rsp_ready = 1'b0;
    send(32'h0, 32'h8C220000, 2'b00);
    send(32'h4, 32'h00221820, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_inst",  64'(rsp_inst),  64'd0);
    chk("post_rst_err",   64'(rsp_err),   64'd0);
    chk("post_rst_occ",   64'(dut.occ_q), 64'd0);
    tick();
    rsp_ready = 1'b1;
    repeat (6) tick();
    send(32'h0, 32'h8C220000, 2'b00);
    drain();

    // random traffic over a programmed window, with concurrent byte writes
    for (int i = 0; i < 64; i++) prog_byte(i, 8'($urandom_range(0, 255)));
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (prog_we) ref_mem[int'(prog_addr % DEPTH)] = prog_data;
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       req_addr = ADDR_W'($urandom_range(0, 15) * 4);
      else if (sel == 8) req_addr = ADDR_W'($urandom_range(0, 60));
      else               req_addr = ADDR_W'(32'h400 + $urandom_range(0, 255));
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = ADDR_W'($urandom_range(0, 63));
      prog_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (req_valid && req_ready) exp_q.push_back(model(req_addr));
      checks++;
      if (int'(dut.occ_q) > RSPD) begin
        failures++;
        $display("FAIL occ_bound actual=%0d required<=%0d", dut.occ_q, RSPD);
      end
    end
    @(posedge clk);
    if (prog_we) ref_mem[int'(prog_addr % DEPTH)] = prog_data;
    #1;
    req_valid = 1'b0;
    prog_we   = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
